// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: opcode codes, FSM state encoding
// and the opcode legality check.
package calc_pkg;

    localparam logic [2:0] OP_MUL  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_SQR  = 3'd3;
    localparam logic [2:0] OP_ADDK = 3'd4;
    localparam logic [2:0] OP_SUBK = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_OP = 2'd1,
        WAIT_B  = 2'd2
    } state_t;

    // upper_zero: every bit of the entered word above bit 2 is zero
    function automatic logic op_legal(input logic upper_zero, input logic [2:0] op);
        return upper_zero && (op != OP_ILL);
    endfunction

endpackage

// File: rtl/calc_edge.sv
// Registered rising-edge detector: pulse is high in the cycle where sig is
// high and was sampled low on the previous clock edge.
module calc_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic sig_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sig_d <= 1'b0;
        else
            sig_d <= sig;
    end

    assign pulse = sig & ~sig_d;

endmodule

// File: rtl/calc_param.sv
// Entry-driven calculator: operand / opcode / operand sequencing on a shared
// bus with WIDTH-bit results and overflow, error and done flags.
// Optional feature: define CALC_CHAIN_EN to chain results into the next opcode.
//
// state   | meaning
// WAIT_A  | waiting for the first operand
// WAIT_OP | showing the operand, waiting for an opcode
// WAIT_B  | showing the binary opcode, waiting for the second operand
module calc_param
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validIn,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             ovf,
    output logic             err,
    output logic             done
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t           state, state_n;
    logic [WIDTH-1:0] number, number_n;
    logic [2:0]       opcode, opcode_n;
    logic [WIDTH-1:0] dout_n;
    logic             ovf_n, err_n, done_n;

    logic             entry;
    logic             upper_zero;
    logic [2:0]       op_in;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] operand_b;
    logic [W2-1:0]    a_ext, b_ext, mul_b, wide;
    logic [WIDTH-1:0] res;
    logic             res_ovf;
    logic             result_hit;

    calc_edge u_edge (
        .clk   (clk),
        .rst   (rst),
        .sig   (validIn),
        .pulse (entry)
    );

    assign upper_zero = (dataIn[WIDTH-1:3] == '0);
    assign op_in      = dataIn[2:0];

    // In WAIT_B the stored opcode works on the bus operand; otherwise the
    // opcode on the bus is unary and its second operand is the constant.
    always_comb begin
        alu_op    = (state == WAIT_B) ? opcode : op_in;
        operand_b = (state == WAIT_B) ? dataIn : STEP_W;
        a_ext     = {{WIDTH{1'b0}}, number};
        b_ext     = {{WIDTH{1'b0}}, operand_b};
        mul_b     = (alu_op == OP_SQR) ? a_ext : b_ext;
        wide      = '0;
        res_ovf   = 1'b0;
        case (alu_op)
            OP_MUL, OP_SQR: begin
                wide    = a_ext * mul_b;
                res_ovf = |wide[W2-1:WIDTH];
            end
            OP_ADD, OP_ADDK: begin
                wide    = a_ext + b_ext;
                res_ovf = wide[WIDTH];
            end
            OP_SUB, OP_SUBK: begin
                wide    = a_ext - b_ext;
                res_ovf = (number < operand_b);
            end
            default: begin
                wide    = '0;
                res_ovf = 1'b0;
            end
        endcase
        res = wide[WIDTH-1:0];
    end

    always_comb begin
        state_n    = state;
        number_n   = number;
        opcode_n   = opcode;
        dout_n     = dataOut;
        ovf_n      = ovf;
        err_n      = err;
        done_n     = 1'b0;
        result_hit = 1'b0;

        if (entry) begin
            case (state)
                WAIT_A: begin
                    number_n = dataIn;
                    dout_n   = dataIn;
                    state_n  = WAIT_OP;
                end
                WAIT_OP: begin
                    if (!op_legal(upper_zero, op_in)) begin
                        err_n = 1'b1;
                    end else begin
                        err_n = 1'b0;
                        case (op_in)
                            OP_MUL, OP_ADD, OP_SUB: begin
                                opcode_n = op_in;
                                dout_n   = dataIn;
                                state_n  = WAIT_B;
                            end
                            OP_SQR, OP_ADDK, OP_SUBK: begin
                                result_hit = 1'b1;
                            end
                            OP_CLR: begin
                                number_n = '0;
                                dout_n   = '0;
                                ovf_n    = 1'b0;
                                state_n  = WAIT_A;
                            end
                            default: begin
                                err_n = 1'b1;
                            end
                        endcase
                    end
                end
                WAIT_B: begin
                    result_hit = 1'b1;
                end
                default: begin
                    state_n = WAIT_A;
                end
            endcase
        end

        if (result_hit) begin
            dout_n = res;
            ovf_n  = res_ovf;
            done_n = 1'b1;
`ifdef CALC_CHAIN_EN
            number_n = res;
            state_n  = WAIT_OP;
`else
            state_n  = WAIT_A;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WAIT_A;
            number  <= '0;
            opcode  <= '0;
            dataOut <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            number  <= number_n;
            opcode  <= opcode_n;
            dataOut <= dout_n;
            ovf     <= ovf_n;
            err     <= err_n;
            done    <= done_n;
        end
    end

endmodule
